rand_walk_decider: RTL and testbench
====================================

Name: rand_walk_decider

Overview:
- Parametrised successor to the team's fixed 8-state threshold/random-bit decision FSM.
- Runs one decision round per start (or free-runs), with configurable pre-delay, trial count and bonus trials.
- Round latency is constant, and a done/h/l result is produced with optional result statistics.
- Sits between the LFSR random-bit source and the game/scoring logic.

Parameters:
- PRE_CYC, 2, idle cycles between round start and threshold sample (>=0).
- STEPS, 3, random-bit trials on the high-threshold track (>=1).
- BONUS, 1, extra trials granted on the low-threshold track; also the gap length on the high track (>=0).
- AUTO, 0, 1 = free-run: a new round starts in the cycle after RES without needing start.
- CNT_W, 8, statistics counter width.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a round; sampled only in IDLE.
- thrsh  in  1  threshold bit; sampled once per round in THR.
- rndbt  in  1  random bit; sampled every WALK cycle.
- busy  out  1  high from the cycle after start is accepted through RES inclusive.
- done  out  1  one-cycle pulse in RES.
- h  out  1  high result, valid only with done.
- l  out  1  low result, valid only with done.
- clr_stats  in  1  synchronous clear of the statistics counters.
- hi_cnt  out  CNT_W  count of h results.
- lo_cnt  out  CNT_W  count of l results.
- nul_cnt  out  CNT_W  count of rounds that ended with neither h nor l.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE; busy, done, h, l = 0.
  - All counters = 0; trial counter and track flag = 0.
  - Reset mid-round aborts the round with no result.
- States: IDLE -> PRE -> THR -> (GAP) -> WALK -> (HOLD) -> RES.
- IDLE: start=1 (or AUTO=1) -> PRE. If PRE_CYC=0, go directly to THR.
- PRE: stays PRE_CYC cycles -> THR.
- THR: one cycle; latches trk = thrsh.
  - trk=1: go to GAP for BONUS cycles, then WALK with STEPS trials. If BONUS=0, go directly to WALK.
  - trk=0: go to WALK with STEPS+BONUS trials.
- WALK: each cycle samples rndbt.
  - rndbt=1: latch hit, go to HOLD.
  - rndbt=0: decrement trials. When trials reach 0 without a hit -> RES.
- HOLD: burns the remaining trial cycles so that the walk window is exactly STEPS+BONUS cycles on every path -> RES.
- RES: done=1 for one cycle.
  - hit -> h=1.
  - no hit and trk=1 -> l=1.
  - no hit and trk=0 -> h=0, l=0 (null result).
  - h and l are never both 1.
  - Next state: IDLE, or PRE if AUTO=1.
- Latency: with start accepted at cycle 0, done occurs at cycle PRE_CYC+2+STEPS+BONUS. Defaults give cycle 8, independent of path and data.
- start is ignored while busy=1; no queueing.
- thrsh and rndbt are ignored outside THR and WALK respectively.
- Counters:
  - Increment in RES on the matching result and saturate at all-ones.
  - clr_stats has priority over an increment in the same cycle.

Optional Feature:
- Macro: RAND_WALK_STATS_EN.
- Defined: hi_cnt, lo_cnt and nul_cnt are implemented as specified, and clr_stats is honoured.
- Undefined: no counter flops are built; the three counter outputs are tied to 0 and clr_stats is ignored. All other behaviour is identical.

Test Plan:
- Defaults, start pulse at cycle 0, thrsh=1, rndbt=0 throughout -> busy cycles 1-8, done at cycle 8 with l=1, h=0; lo_cnt=1.
- Defaults, thrsh=0, rndbt=0 throughout -> done at cycle 8 with h=0, l=0; nul_cnt=1.
- Defaults, thrsh=0, rndbt=1 only on the 2nd WALK cycle -> done still at cycle 8 with h=1; hi_cnt=1; later rndbt toggles have no effect.
- AUTO=1, STEPS=2, BONUS=0, PRE_CYC=0, thrsh=1, rndbt=1 -> done every 4 cycles, h=1 each round. With STATS on and CNT_W=2, hi_cnt saturates at 3.
- start re-asserted at cycle 4 of a round -> ignored, single done. rst_n=0 at cycle 5 -> busy=0 immediately, no done, counters=0.
- clr_stats=1 in the same cycle as RES with h=1 -> hi_cnt=0 afterwards. With the macro undefined, all counters read 0 throughout every scenario above.

Source files
------------

// File: rtl/rand_walk_decider_if.sv
// Bus bundle for rand_walk_decider: round control, random inputs, result
// strobes and the optional statistics counters.
// The master side (game/scoring logic plus the LFSR source) drives start,
// thrsh, rndbt and clr_stats. The slave side (the decider) drives the rest.
interface rand_walk_decider_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             thrsh;
  logic             rndbt;
  logic             clr_stats;
  logic             busy;
  logic             done;
  logic             h;
  logic             l;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] lo_cnt;
  logic [CNT_W-1:0] nul_cnt;

  modport master (
    output start, thrsh, rndbt, clr_stats,
    input  busy, done, h, l, hi_cnt, lo_cnt, nul_cnt
  );

  modport slave (
    input  start, thrsh, rndbt, clr_stats,
    output busy, done, h, l, hi_cnt, lo_cnt, nul_cnt
  );
endinterface

// File: rtl/rand_walk_decider.sv
// rand_walk_decider: one threshold/random-walk decision round per start
// (or back-to-back when AUTO=1).
// Round shape: IDLE -> PRE -> THR -> (GAP) -> WALK -> (HOLD) -> RES.
// The walk window (GAP + WALK + HOLD) is always STEPS+BONUS cycles, so done
// arrives PRE_CYC+2+STEPS+BONUS cycles after start is accepted, whatever the
// threshold and random data were.
// Optional statistics counters are built only when RAND_WALK_STATS_EN is
// defined; otherwise the counter outputs are tied to zero and clr_stats is
// ignored.
module rand_walk_decider #(
  parameter int PRE_CYC = 2,
  parameter int STEPS   = 3,
  parameter int BONUS   = 1,
  parameter int AUTO    = 0,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rand_walk_decider_if.slave   bus
);

  // One shared down-counter serves PRE, GAP, WALK and HOLD. It must hold the
  // largest load value, which is either the pre-delay or the full window.
  localparam int WIN  = STEPS + BONUS;
  localparam int MAXC = (PRE_CYC > WIN) ? PRE_CYC : WIN;
  localparam int TW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);

  localparam logic [TW-1:0] PRE_LD   = TW'(PRE_CYC);
  localparam logic [TW-1:0] STEPS_LD = TW'(STEPS);
  localparam logic [TW-1:0] BONUS_LD = TW'(BONUS);
  localparam logic [TW-1:0] WIN_LD   = TW'(WIN);
  localparam logic [TW-1:0] ONE      = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_THR  = 3'd2,
    S_GAP  = 3'd3,
    S_WALK = 3'd4,
    S_HOLD = 3'd5,
    S_RES  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q,   cnt_d;
  logic          trk_q,   trk_d;
  logic          hit_q,   hit_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic          h_q,     h_d;
  logic          l_q,     l_d;
  logic          begin_round;

  // Next-state logic for the round sequencer, plus the registered result
  // strobes derived from where the sequencer is heading.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    trk_d       = trk_q;
    hit_d       = hit_q;
    begin_round = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start || (AUTO != 0)) begin
          begin_round = 1'b1;
        end
      end

      S_PRE: begin
        if (cnt_q <= ONE) begin
          state_d = S_THR;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      // The threshold is looked at exactly once per round; the hit flag from
      // the previous round is discarded here.
      S_THR: begin
        trk_d = bus.thrsh;
        hit_d = 1'b0;
        if (bus.thrsh && (BONUS > 0)) begin
          state_d = S_GAP;
          cnt_d   = BONUS_LD;
        end else begin
          state_d = S_WALK;
          cnt_d   = bus.thrsh ? STEPS_LD : WIN_LD;
        end
      end

      // High track sits out BONUS cycles before its shorter walk, keeping
      // the window length equal to the low track's longer walk.
      S_GAP: begin
        if (cnt_q <= ONE) begin
          state_d = S_WALK;
          cnt_d   = STEPS_LD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      // A hit on the final trial goes straight to RES; an earlier hit parks
      // in HOLD for the trials that are left.
      S_WALK: begin
        if (bus.rndbt) begin
          hit_d = 1'b1;
        end
        if (cnt_q <= ONE) begin
          state_d = S_RES;
        end else begin
          cnt_d = cnt_q - ONE;
          if (bus.rndbt) begin
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (cnt_q <= ONE) begin
          state_d = S_RES;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      S_RES: begin
        if (AUTO != 0) begin
          begin_round = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Round entry is shared by IDLE+start and RES in free-run mode. With no
    // pre-delay the threshold is sampled in the very next cycle.
    if (begin_round) begin
      if (PRE_CYC == 0) begin
        state_d = S_THR;
      end else begin
        state_d = S_PRE;
        cnt_d   = PRE_LD;
      end
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_RES);
    h_d    = done_d & hit_d;
    l_d    = done_d & ~hit_d & trk_d;
  end

  // Sequencer and result registers; reset aborts any round in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      trk_q   <= 1'b0;
      hit_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      h_q     <= 1'b0;
      l_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trk_q   <= trk_d;
      hit_q   <= hit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      h_q     <= h_d;
      l_q     <= l_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.h    = h_q;
  assign bus.l    = l_q;

`ifdef RAND_WALK_STATS_EN
  logic [CNT_W-1:0] hi_cnt_q,  hi_cnt_d;
  logic [CNT_W-1:0] lo_cnt_q,  lo_cnt_d;
  logic [CNT_W-1:0] nul_cnt_q, nul_cnt_d;
  logic             nul_res;

  // Saturating result tallies, counted while the RES strobes are visible;
  // a clear wins over a same-cycle increment.
  always_comb begin
    hi_cnt_d  = hi_cnt_q;
    lo_cnt_d  = lo_cnt_q;
    nul_cnt_d = nul_cnt_q;
    nul_res   = done_q & ~h_q & ~l_q;
    if (bus.clr_stats) begin
      hi_cnt_d  = '0;
      lo_cnt_d  = '0;
      nul_cnt_d = '0;
    end else begin
      if (done_q && h_q && !(&hi_cnt_q)) begin
        hi_cnt_d = hi_cnt_q + 1'b1;
      end
      if (done_q && l_q && !(&lo_cnt_q)) begin
        lo_cnt_d = lo_cnt_q + 1'b1;
      end
      if (nul_res && !(&nul_cnt_q)) begin
        nul_cnt_d = nul_cnt_q + 1'b1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt_q  <= '0;
      lo_cnt_q  <= '0;
      nul_cnt_q <= '0;
    end else begin
      hi_cnt_q  <= hi_cnt_d;
      lo_cnt_q  <= lo_cnt_d;
      nul_cnt_q <= nul_cnt_d;
    end
  end

  assign bus.hi_cnt  = hi_cnt_q;
  assign bus.lo_cnt  = lo_cnt_q;
  assign bus.nul_cnt = nul_cnt_q;
`else
  // Statistics not built: counters read as zero and clr_stats has no effect.
  assign bus.hi_cnt  = '0;
  assign bus.lo_cnt  = '0;
  assign bus.nul_cnt = '0;
`endif

endmodule

// File: tb/tb_rand_walk_decider.sv
// Bench for rand_walk_decider: a table of fixed rounds, hand-written
// multi-cycle sequences (restart while busy, mid-round reset, clear in RES,
// free-run saturation) and randomized rounds checked against a behavioural
// model of the decision rule. Counter expectations follow
// RAND_WALK_STATS_EN.
`timescale 1ns/1ps
module tb_rand_walk_decider;

  localparam int PRE     = 2;
  localparam int ST      = 3;
  localparam int BO      = 1;
  localparam int CW      = 8;
  localparam int WIN     = ST + BO;
  localparam int THR_C   = PRE + 1;
  localparam int WSTART  = PRE + 2;
  localparam int DONE_AT = PRE + 2 + ST + BO;
  localparam int SAT     = (1 << CW) - 1;

`ifdef RAND_WALK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst2_n;

  rand_walk_decider_if #(.CNT_W(CW)) a ();
  rand_walk_decider_if #(.CNT_W(2))  b ();

  rand_walk_decider #(
    .PRE_CYC(PRE), .STEPS(ST), .BONUS(BO), .AUTO(0), .CNT_W(CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (a.slave)
  );

  rand_walk_decider #(
    .PRE_CYC(0), .STEPS(2), .BONUS(0), .AUTO(1), .CNT_W(2)
  ) dut2 (
    .clk  (clk),
    .rst_n(rst2_n),
    .bus  (b.slave)
  );

  int total = 0;
  int bad   = 0;
  int m_hi  = 0;
  int m_lo  = 0;
  int m_nul = 0;

  typedef struct {
    logic           thr;
    logic [WIN-1:0] pat;
    logic           eh;
    logic           el;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end else begin
      $display("ok   %s = %0d", nm, got);
    end
  endtask

  // Decision rule: the low track walks over the whole window, the high track
  // only over the last STEPS cycles. Any 1 seen in the walk is a hit.
  function automatic void model(input logic thr, input logic [WIN-1:0] pat,
                                output logic eh, output logic el);
    logic hit;
    int   first;
    hit   = 1'b0;
    first = thr ? BO : 0;
    for (int i = first; i < WIN; i++) begin
      if (pat[i]) hit = 1'b1;
    end
    eh = hit;
    el = !hit && thr;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  // One full round on dut: start in cycle 0, thrsh valid only in THR,
  // pattern bits only in the walk window, noise everywhere else.
  task automatic run_round(input string nm, input logic thr, input logic [WIN-1:0] pat,
                           input logic eh, input logic el, input bit restart4, input bit clr_res);
    int   ndone = 0;
    int   dcyc  = -1;
    int   bbad  = 0;
    logic gh    = 1'b0;
    logic gl    = 1'b0;
    @(negedge clk);
    a.start     = 1'b1;
    a.thrsh     = 1'($urandom);
    a.rndbt     = 1'($urandom);
    a.clr_stats = 1'b0;
    for (int c = 1; c <= DONE_AT + 1; c++) begin
      @(negedge clk);
      if (a.busy !== (c <= DONE_AT)) bbad++;
      if (a.done === 1'b1) begin
        ndone++;
        dcyc = c;
        gh   = a.h;
        gl   = a.l;
      end
      if (c == DONE_AT + 1) begin
        if (clr_res) begin
          m_hi = 0; m_lo = 0; m_nul = 0;
        end else if (eh) begin
          m_hi = sat_inc(m_hi);
        end else if (el) begin
          m_lo = sat_inc(m_lo);
        end else begin
          m_nul = sat_inc(m_nul);
        end
        chk({nm, " hi_cnt"},  32'(a.hi_cnt),  STATS ? 32'(m_hi)  : 32'd0);
        chk({nm, " lo_cnt"},  32'(a.lo_cnt),  STATS ? 32'(m_lo)  : 32'd0);
        chk({nm, " nul_cnt"}, 32'(a.nul_cnt), STATS ? 32'(m_nul) : 32'd0);
      end
      if (c <= DONE_AT) a.start = (restart4 && c == 4) ? 1'b1 : 1'($urandom);
      else              a.start = 1'b0;
      a.thrsh     = (c == THR_C) ? thr : 1'($urandom);
      a.rndbt     = (c >= WSTART && c < WSTART + WIN) ? pat[c - WSTART] : 1'($urandom);
      a.clr_stats = clr_res && (c == DONE_AT);
    end
    a.start = 1'b0;
    $display("round %s thr=%0b pat=%b done@%0d h=%0b l=%0b", nm, thr, pat, dcyc, gh, gl);
    chk({nm, " done_count"}, 32'(ndone), 32'd1);
    chk({nm, " done_cycle"}, 32'(dcyc),  32'(DONE_AT));
    chk({nm, " busy_errs"},  32'(bbad),  32'd0);
    chk({nm, " h"}, 32'(gh), 32'(eh));
    chk({nm, " l"}, 32'(gl), 32'(el));
  endtask

  initial begin
    logic           eh, el, thr;
    logic [WIN-1:0] pat;
    int             errs;
    int             herrs;
    int             hcnt_errs;
    int             nd;

    tbl[0] = '{thr: 1'b1, pat: 4'b0000, eh: 1'b0, el: 1'b1};
    tbl[1] = '{thr: 1'b0, pat: 4'b0000, eh: 1'b0, el: 1'b0};
    tbl[2] = '{thr: 1'b0, pat: 4'b1010, eh: 1'b1, el: 1'b0};
    tbl[3] = '{thr: 1'b1, pat: 4'b0001, eh: 1'b0, el: 1'b1};
    tbl[4] = '{thr: 1'b1, pat: 4'b0100, eh: 1'b1, el: 1'b0};
    tbl[5] = '{thr: 1'b0, pat: 4'b1000, eh: 1'b1, el: 1'b0};
    tbl[6] = '{thr: 1'b1, pat: 4'b1000, eh: 1'b1, el: 1'b0};
    tbl[7] = '{thr: 1'b0, pat: 4'b0001, eh: 1'b1, el: 1'b0};
    tbl[8] = '{thr: 1'b1, pat: 4'b1111, eh: 1'b1, el: 1'b0};

    rst_n = 1'b0; rst2_n = 1'b0;
    a.start = 1'b0; a.thrsh = 1'b0; a.rndbt = 1'b0; a.clr_stats = 1'b0;
    b.start = 1'b0; b.thrsh = 1'b1; b.rndbt = 1'b1; b.clr_stats = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy",    32'(a.busy),    32'd0);
    chk("rst done",    32'(a.done),    32'd0);
    chk("rst h",       32'(a.h),       32'd0);
    chk("rst l",       32'(a.l),       32'd0);
    chk("rst hi_cnt",  32'(a.hi_cnt),  32'd0);
    chk("rst lo_cnt",  32'(a.lo_cnt),  32'd0);
    chk("rst nul_cnt", 32'(a.nul_cnt), 32'd0);
    chk("rst2 done",   32'(b.done),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_round($sformatf("tbl%0d", i), tbl[i].thr, tbl[i].pat, tbl[i].eh, tbl[i].el, 1'b0, 1'b0);
    end

    // start re-asserted in cycle 4 must not queue a second round
    run_round("restart4", 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
    errs = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (a.busy !== 1'b0 || a.done !== 1'b0) errs++;
    end
    chk("restart4 quiet_after", 32'(errs), 32'd0);

    // clear in the same cycle as an h result wins over the increment
    run_round("clr_res", 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);

    for (int r = 0; r < 40; r++) begin
      thr = 1'($urandom);
      pat = ($urandom_range(0, 2) == 0) ? '0 : WIN'($urandom);
      model(thr, pat, eh, el);
      run_round($sformatf("rnd%0d", r), thr, pat, eh, el, 1'b0, 1'b0);
    end

    // reset at cycle 5 of a round: busy drops at once, no result, stats zero
    @(negedge clk);
    a.start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      a.start = 1'b0;
      a.thrsh = 1'b1;
      a.rndbt = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    $display("mid-round reset applied");
    chk("midrst busy",    32'(a.busy),    32'd0);
    chk("midrst done",    32'(a.done),    32'd0);
    chk("midrst hi_cnt",  32'(a.hi_cnt),  32'd0);
    chk("midrst lo_cnt",  32'(a.lo_cnt),  32'd0);
    chk("midrst nul_cnt", 32'(a.nul_cnt), 32'd0);
    m_hi = 0; m_lo = 0; m_nul = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (a.busy !== 1'b0 || a.done !== 1'b0) errs++;
    end
    chk("midrst no_result", 32'(errs), 32'd0);
    run_round("post_rst", 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // free-run instance: done every 4 cycles, always h, hi_cnt saturates at 3
    rst2_n = 1'b1;
    errs = 0; herrs = 0; hcnt_errs = 0; nd = 0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (b.hi_cnt !== (STATS ? 2'((nd > 3) ? 3 : nd) : 2'd0)) hcnt_errs++;
      if (b.done !== ((c % 4) == 0)) errs++;
      if (b.done === 1'b1) begin
        if (b.h !== 1'b1 || b.l !== 1'b0) herrs++;
        nd++;
      end
      if (b.busy !== 1'b1) errs++;
    end
    $display("auto run dones=%0d hi_cnt=%0d", nd, b.hi_cnt);
    chk("auto done_timing", 32'(errs), 32'd0);
    chk("auto hl",          32'(herrs), 32'd0);
    chk("auto hi_cnt_trk",  32'(hcnt_errs), 32'd0);
    chk("auto hi_cnt_sat",  32'(b.hi_cnt), STATS ? 32'd3 : 32'd0);
    chk("auto lo_cnt",      32'(b.lo_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
